// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter and byte sequencer that shares one UART transmitter
// between NUM_REQ byte-stream clients. A grant is held for a whole message.
// It is released when the client marks the last byte, when the client drops
// its request, or when MAX_BURST bytes have been sent. Bytes go to the
// transmitter through a start/busy handshake.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, a watchdog counts cycles spent in WAIT_VALID or WAIT_ACK.
//   After TIMEOUT_CYC cycles it sets the sticky err_o and releases the grant.
//   When undefined, err_o is tied low and the arbiter may wait indefinitely.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   req_i        per-requester request level
//   req_valid_i  per-requester byte valid
//   req_last_i   per-requester "this byte ends the message"
//   req_data_i   packed bytes, requester i at [i*DATA_BIT +: DATA_BIT]
//   req_ready_o  one-cycle pulse when the granted requester's byte is taken
//   grant_o      registered one-hot grant
//   tx_data_o    byte to the transmitter, stable until the next accepted byte
//   tx_start_o   one-cycle start pulse to the transmitter
//   tx_busy_i    transmitter busy
//   err_o        sticky watchdog error (0 without UART_ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_BIT    = 8,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ-1:0]          req_last_i,
    input  logic [NUM_REQ*DATA_BIT-1:0] req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic [DATA_BIT-1:0]         tx_data_o,
    output logic                        tx_start_o,
    input  logic                        tx_busy_i,
    output logic                        err_o
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int IW1  = IDXW + 1;
    localparam logic [IDXW:0] NUM_REQ_W   = IW1'(NUM_REQ);
    localparam logic [7:0]    MAX_BURST_W = 8'(MAX_BURST);

    // Reject parameter values the counters and index arithmetic cannot hold.
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 ||
        TIMEOUT_CYC < 1 || DATA_BIT < 1) begin : gBadParams
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VALID,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        RELEASE
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [IDXW-1:0]      gIdx_q, gIdx_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;
    logic [7:0]           burst_q, burst_d;
    logic                 last_q, last_d;
    logic [DATA_BIT-1:0]  txData_q, txData_d;
    logic                 txStart_q, txStart_d;

`ifdef UART_ARB_TIMEOUT_EN
    logic                 err_q, err_d;
    logic [31:0]          tmoCnt_q, tmoCnt_d;
    logic                 tmoHit;

    assign tmoHit = (tmoCnt_q == 32'(TIMEOUT_CYC - 1));
`endif

    // Round-robin pick: first requesting index at or after the pointer,
    // searching upward with wrap. Index sums use one extra bit so the wrap
    // works for NUM_REQ values that are not powers of two.
    logic [IDXW-1:0] pickIdx;
    logic [IDXW:0]   candIdx;
    logic            pickFound;

    always_comb begin
        pickIdx   = ptr_q;
        pickFound = 1'b0;
        candIdx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            candIdx = {1'b0, ptr_q} + IW1'(i);
            if (candIdx >= NUM_REQ_W) begin
                candIdx = candIdx - NUM_REQ_W;
            end
            if (!pickFound && req_i[candIdx[IDXW-1:0]]) begin
                pickFound = 1'b1;
                pickIdx   = candIdx[IDXW-1:0];
            end
        end
    end

    // Pointer value after releasing the current grant (gIdx + 1, wrapped).
    logic [IDXW:0]   nextPtrW;
    logic [IDXW-1:0] nextPtr;

    assign nextPtrW = {1'b0, gIdx_q} + IW1'(1);
    assign nextPtr  = (nextPtrW >= NUM_REQ_W) ? '0 : nextPtrW[IDXW-1:0];

    // Byte lane of the granted requester.
    logic [DATA_BIT-1:0] selData;

    always_comb begin
        selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gIdx_q == IDXW'(i)) begin
                selData = req_data_i[i*DATA_BIT +: DATA_BIT];
            end
        end
    end

    // Next-state logic. The grant is cleared on entry to RELEASE so GRANT is
    // already low in the RELEASE cycle. IDLE then takes another cycle, which
    // guarantees a gap between consecutive grants.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gIdx_d    = gIdx_q;
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        last_d    = last_q;
        txData_d  = txData_q;
        ready_d   = '0;
        txStart_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        err_d     = err_q;
        tmoCnt_d  = '0;
`endif

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d = NUM_REQ'(1) << pickIdx;
                    gIdx_d  = pickIdx;
                    state_d = WAIT_VALID;
                end
            end

            WAIT_VALID: begin
                // A valid byte wins over a request falling in the same cycle.
                if (req_valid_i[gIdx_q]) begin
                    txData_d        = selData;
                    last_d          = req_last_i[gIdx_q];
                    ready_d[gIdx_q] = 1'b1;
                    state_d         = ISSUE;
                end else if (!req_i[gIdx_q]) begin
                    grant_d = '0;
                    state_d = RELEASE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (tmoHit) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = RELEASE;
                end
`endif
            end

            ISSUE: begin
                txStart_d = 1'b1;
                burst_d   = burst_q + 8'd1;
                state_d   = WAIT_ACK;
            end

            WAIT_ACK: begin
                // A busy level that is already high is taken as the acknowledge.
                if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (tmoHit) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = RELEASE;
                end
`endif
            end

            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    if (last_q || (burst_q == MAX_BURST_W) || !req_i[gIdx_q]) begin
                        grant_d = '0;
                        state_d = RELEASE;
                    end else begin
                        state_d = WAIT_VALID;
                    end
                end
            end

            RELEASE: begin
                grant_d = '0;
                ptr_d   = nextPtr;
                burst_d = '0;
                state_d = IDLE;
            end

            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

`ifdef UART_ARB_TIMEOUT_EN
        // The watchdog counts only while staying in a waiting state.
        if ((state_d == state_q) && ((state_q == WAIT_VALID) || (state_q == WAIT_ACK))) begin
            tmoCnt_d = tmoCnt_q + 32'd1;
        end
`endif
    end

    // All state and outputs are registered. Reset clears them asynchronously,
    // which drops the grant immediately even in the middle of a frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ready_q   <= '0;
            gIdx_q    <= '0;
            ptr_q     <= '0;
            burst_q   <= '0;
            last_q    <= 1'b0;
            txData_q  <= '0;
            txStart_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
            tmoCnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ready_q   <= ready_d;
            gIdx_q    <= gIdx_d;
            ptr_q     <= ptr_d;
            burst_q   <= burst_d;
            last_q    <= last_d;
            txData_q  <= txData_d;
            txStart_q <= txStart_d;
`ifdef UART_ARB_TIMEOUT_EN
            err_q     <= err_d;
            tmoCnt_q  <= tmoCnt_d;
`endif
        end
    end

    assign grant_o     = grant_q;
    assign req_ready_o = ready_q;
    assign tx_data_o   = txData_q;
    assign tx_start_o  = txStart_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4).
//
// Structure:
//   - Client models present queued bytes on each lane.
//   - A transmitter model raises busy for a fixed frame length after each
//     start pulse.
//   - The expected transmit order is pushed into a scoreboard queue by the
//     stimulus.
//   - A monitor pops the scoreboard on every start pulse and compares the
//     byte and the grant. It also watches the ready pulses and the grant
//     transitions.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_BIT  = 8;
    localparam int MAX_BURST = 4;
    localparam int BUSY_LEN  = 20;
    localparam int SRC_DEPTH = 16;

    logic                        clk = 1'b0;
    logic                        rstN;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          reqValid;
    logic [NUM_REQ-1:0]          reqLast;
    logic [NUM_REQ*DATA_BIT-1:0] reqData;
    logic [NUM_REQ-1:0]          reqReady;
    logic [NUM_REQ-1:0]          grant;
    logic [DATA_BIT-1:0]         txData;
    logic                        txStart;
    logic                        txBusy;
    logic                        err;

    int checks      = 0;
    int failures    = 0;
    int startCount  = 0;
    int readyCount  = 0;

    logic [8:0]         srcMem [NUM_REQ][SRC_DEPTH];
    int                 srcHead [NUM_REQ];
    int                 srcTail [NUM_REQ];
    logic [NUM_REQ-1:0] reqHold;
    logic [15:0]        expQ [$];

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_BIT   (DATA_BIT),
        .MAX_BURST  (MAX_BURST),
        .TIMEOUT_CYC(65535)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .req_i      (req),
        .req_valid_i(reqValid),
        .req_last_i (reqLast),
        .req_data_i (reqData),
        .req_ready_o(reqReady),
        .grant_o    (grant),
        .tx_data_o  (txData),
        .tx_start_o (txStart),
        .tx_busy_i  (txBusy),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // Compares one value and records the outcome.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Queues one byte on a client lane.
    task automatic applyStimulus(input int idx, input logic [7:0] data, input logic last);
        srcMem[idx][srcTail[idx]] = {last, data};
        srcTail[idx]++;
    endtask

    task automatic expectByte(input int idx, input logic [7:0] data);
        expQ.push_back({8'(idx), data});
    endtask

    function automatic bit sourcesEmpty();
        bit empty = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (srcHead[i] != srcTail[i]) empty = 1'b0;
        end
        return empty;
    endfunction

    task automatic clearSources();
        for (int i = 0; i < NUM_REQ; i++) begin
            srcHead[i] = 0;
            srcTail[i] = 0;
        end
    endtask

    task automatic driveSources();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (srcHead[i] < srcTail[i]) begin
                reqValid[i]                     = 1'b1;
                reqLast[i]                      = srcMem[i][srcHead[i]][8];
                reqData[i*DATA_BIT +: DATA_BIT] = srcMem[i][srcHead[i]][7:0];
                req[i]                          = 1'b1;
            end else begin
                reqValid[i]                     = 1'b0;
                reqLast[i]                      = 1'b0;
                reqData[i*DATA_BIT +: DATA_BIT] = '0;
                req[i]                          = reqHold[i];
            end
        end
    endtask

    // Client models: advance a lane when its ready pulse is seen.
    initial begin
        req      = '0;
        reqValid = '0;
        reqLast  = '0;
        reqData  = '0;
        reqHold  = '0;
        clearSources();
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (reqReady[i] && (srcHead[i] < srcTail[i])) srcHead[i]++;
            end
            driveSources();
        end
    end

    // Transmitter model: busy from the cycle after start for one frame.
    initial begin
        txBusy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (txStart) begin
                @(posedge clk);
                #1;
                txBusy = 1'b1;
                repeat (BUSY_LEN - 1) @(posedge clk);
                #1;
                txBusy = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [NUM_REQ-1:0] prevGrant;
        logic [NUM_REQ-1:0] prevReady;
        logic [NUM_REQ-1:0] expGrant;
        logic               prevStart;
        logic [15:0]        entry;
        prevGrant = '0;
        prevReady = '0;
        prevStart = 1'b0;
        forever begin
            @(negedge clk);
            if (txStart) begin
                startCount++;
                checkOutput("start_width", 32'(prevStart), 32'd0);
                checkOutput("ready_before_start", 32'(prevReady), 32'(grant));
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_start actual=%0h required=none", txData);
                end else begin
                    entry    = expQ.pop_front();
                    expGrant = NUM_REQ'(1) << entry[15:8];
                    checkOutput("tx_data", 32'(txData), 32'(entry[7:0]));
                    checkOutput("tx_grant", 32'(grant), 32'(expGrant));
                end
            end
            if (|reqReady) begin
                readyCount++;
                checkOutput("ready_granted", 32'(reqReady), 32'(grant));
            end
            if (grant != prevGrant) begin
                checkOutput("grant_onehot", 32'($onehot0(grant)), 32'd1);
                checkOutput("grant_gap", 32'((prevGrant == '0) || (grant == '0)), 32'd1);
            end
            prevGrant = grant;
            prevReady = reqReady;
            prevStart = txStart;
        end
    end

    task automatic waitIdle(input string name);
        int quiet = 0;
        int n     = 0;
        while (quiet < 4 && n < 3000) begin
            @(negedge clk);
            n++;
            if (grant == '0 && !txBusy && expQ.size() == 0 && sourcesEmpty()) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_idle actual=busy required=idle pending=%0d", name, expQ.size());
        end
    endtask

    task automatic waitGrant(input string name, input logic [NUM_REQ-1:0] value);
        int n = 0;
        while (grant != value && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(grant), 32'(value));
    endtask

    task automatic waitStart(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!txStart && n < 200);
        checkOutput(name, 32'(txStart), 32'd1);
    endtask

    task automatic checkCounts(input string name, input int expected);
        checkOutput({name, "_starts"}, 32'(startCount), 32'(expected));
        checkOutput({name, "_readies"}, 32'(readyCount), 32'(expected));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int n;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_grant", 32'(grant), 32'd0);
        checkOutput("reset_ready", 32'(reqReady), 32'd0);
        checkOutput("reset_start", 32'(txStart), 32'd0);
        checkOutput("reset_data", 32'(txData), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_grant", 32'(grant), 32'd0);

        // Single requester, three-byte message.
        $display("[TB] test single requester");
        applyStimulus(0, 8'h41, 1'b0);
        applyStimulus(0, 8'h42, 1'b0);
        applyStimulus(0, 8'h43, 1'b1);
        expectByte(0, 8'h41);
        expectByte(0, 8'h42);
        expectByte(0, 8'h43);
        waitGrant("t1_grant", 4'b0001);
        waitIdle("t1");
        checkOutput("t1_grant_released", 32'(grant), 32'd0);
        checkCounts("t1", 3);

        // Request held with no data, then dropped: release without a start.
        $display("[TB] test early drop");
        clearSources();
        reqHold[1] = 1'b1;
        waitGrant("t4_grant", 4'b0010);
        repeat (3) @(negedge clk);
        reqHold[1] = 1'b0;
        waitIdle("t4");
        checkCounts("t4", 3);

        // Burst limit with competing requesters; pointer starts at 2.
        $display("[TB] test burst limit");
        clearSources();
        for (int b = 0; b < 10; b++) applyStimulus(2, 8'(8'h20 + b), 1'b0);
        applyStimulus(1, 8'hD1, 1'b1);
        applyStimulus(3, 8'hD3, 1'b1);
        for (int b = 0; b < 4; b++) expectByte(2, 8'(8'h20 + b));
        expectByte(3, 8'hD3);
        expectByte(1, 8'hD1);
        for (int b = 4; b < 8; b++) expectByte(2, 8'(8'h20 + b));
        expectByte(2, 8'h28);
        expectByte(2, 8'h29);
        waitIdle("t3");
        checkCounts("t3", 15);

        // Asynchronous reset while the transmitter is busy.
        $display("[TB] test reset mid-frame");
        clearSources();
        applyStimulus(0, 8'h5A, 1'b1);
        expectByte(0, 8'h5A);
        waitStart("t5_start");
        repeat (5) @(negedge clk);
        checkOutput("t5_grant_before_reset", 32'(grant), 32'd1);
        checkOutput("t5_data_before_reset", 32'(txData), 32'h5A);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("t5_async_grant", 32'(grant), 32'd0);
        checkOutput("t5_async_data", 32'(txData), 32'd0);
        checkOutput("t5_async_start", 32'(txStart), 32'd0);
        checkOutput("t5_async_ready", 32'(reqReady), 32'd0);
        checkOutput("t5_async_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        n = 0;
        while (txBusy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_busy_settled", 32'(txBusy), 32'd0);
        rstN = 1'b1;
        clearSources();
        applyStimulus(0, 8'h60, 1'b1);
        applyStimulus(3, 8'h63, 1'b1);
        expectByte(0, 8'h60);
        expectByte(3, 8'h63);
        waitIdle("t5");
        checkCounts("t5", 18);

        // Full contention, pointer starts at 0.
        $display("[TB] test contention");
        clearSources();
        applyStimulus(0, 8'hA0, 1'b1);
        applyStimulus(0, 8'hE0, 1'b1);
        applyStimulus(1, 8'hA1, 1'b1);
        applyStimulus(2, 8'hA2, 1'b1);
        applyStimulus(3, 8'hA3, 1'b1);
        expectByte(0, 8'hA0);
        expectByte(1, 8'hA1);
        expectByte(2, 8'hA2);
        expectByte(3, 8'hA3);
        expectByte(0, 8'hE0);
        waitIdle("t2");
        checkCounts("t2", 23);
        checkOutput("final_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
